// File: rtl/ccm_strip_fetch.sv
// ccm_strip_fetch: walks a feature map in ROWS x LANES pixel strips with
// stride 1 or 2. Pixels inside the map are read over the REQ/GRANT/VLD port
// and pixels outside it are written as 0. Each finished strip is then handed
// to the MAC array over a VLD/RDY handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for op_start; configuration captured on start
// S_FETCH | current pixel selected; zero-fill or raise the read request
// S_REQ   | read request held with a stable address until granted
// S_WAIT  | one read outstanding; waiting for read data valid
// S_OUT   | strip presented to the consumer; held until strip_rdy
// S_DONE  | one-cycle completion pulse

module ccm_strip_fetch #(
  parameter int ADDR_W = 20,
  parameter int PX_W   = 16,
  parameter int LANES  = 16,
  parameter int ROWS   = 2,
  parameter int DIM_W  = 9
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_op_start,
  input  logic                         i_op_abort,
  output logic                         o_busy,
  output logic                         o_done,
  input  logic [DIM_W-1:0]             i_cfg_width,
  input  logic [DIM_W-1:0]             i_cfg_height,
  input  logic                         i_cfg_stride2,
  input  logic [ADDR_W-1:0]            i_base_addr,
  output logic                         o_px_rd_req,
  output logic [ADDR_W-1:0]            o_px_rd_addr,
  input  logic                         i_px_rd_grant,
  input  logic                         i_px_rd_vld,
  input  logic [PX_W-1:0]              i_px_rd_data,
  output logic [ROWS*LANES*PX_W-1:0]   o_strip_data,
  output logic                         o_strip_vld,
  input  logic                         i_strip_rdy
);

  // Coordinates can overshoot the map by up to one stepped strip, so they
  // carry a few extra bits beyond the configured dimension width.
  localparam int CW    = DIM_W + $clog2(2 * ROWS * LANES) + 1;
  localparam int RW    = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SLOTS = ROWS * LANES;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [DIM_W-1:0]         r_width;
  logic [DIM_W-1:0]         r_height;
  logic                     r_stride2;
  logic [ADDR_W-1:0]        r_base;
  logic [CW-1:0]            r_x0;
  logic [CW-1:0]            r_y0;
  logic [RW-1:0]            r_row;
  logic [LW-1:0]            r_lane;
  logic [SLOTS*PX_W-1:0]    r_strip;

  logic [CW-1:0]            w_x;
  logic [CW-1:0]            w_y;
  logic                     w_in_bounds;
  logic [ADDR_W-1:0]        w_addr;
  logic [SW-1:0]            w_slot;
  logic                     w_last_px;
  logic [CW-1:0]            w_x0_step;
  logic [CW-1:0]            w_y0_step;
  logic                     w_x_wrap;
  logic                     w_last_strip;

  logic                     w_capture;
  logic                     w_wr_en;
  logic                     w_wr_zero;
  logic                     w_advance;
  logic                     w_strip_acc;
  logic                     w_req;
  logic                     w_done;
  logic                     w_strip_vld;
  logic [PX_W-1:0]          w_wr_data;

  // Current pixel position, bounds test, read address and strip slot.
  assign w_x         = r_x0 + (CW'(r_lane) << r_stride2);
  assign w_y         = r_y0 + (CW'(r_row) << r_stride2);
  assign w_in_bounds = (w_x < CW'(r_width)) && (w_y < CW'(r_height));
  assign w_addr      = r_base + ADDR_W'(w_y) * ADDR_W'(r_width) + ADDR_W'(w_x);
  assign w_slot      = SW'(r_row) * SW'(LANES) + SW'(r_lane);
  assign w_last_px   = (r_row == RW'(ROWS - 1)) && (r_lane == LW'(LANES - 1));
  assign w_wr_data   = w_wr_zero ? '0 : i_px_rd_data;

  // Strip origin stepping; x0 wraps to the next strip row at the right edge.
  assign w_x0_step    = r_x0 + (CW'(LANES) << r_stride2);
  assign w_y0_step    = r_y0 + (CW'(ROWS) << r_stride2);
  assign w_x_wrap     = (w_x0_step >= CW'(r_width));
  assign w_last_strip = w_x_wrap && (w_y0_step >= CW'(r_height));

  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = w_done;
  assign o_px_rd_req  = w_req;
  assign o_px_rd_addr = w_addr;
  assign o_strip_vld  = w_strip_vld;
  assign o_strip_data = r_strip;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake outputs; abort overrides every busy state.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_zero   = 1'b0;
    w_advance   = 1'b0;
    w_strip_acc = 1'b0;
    w_req       = 1'b0;
    w_done      = 1'b0;
    w_strip_vld = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_op_start && !i_op_abort) begin
          w_capture   = 1'b1;
          w_state_nxt = ((i_cfg_width == '0) || (i_cfg_height == '0)) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!w_in_bounds) begin
          w_wr_en     = 1'b1;
          w_wr_zero   = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = w_last_px ? S_OUT : S_FETCH;
        end else begin
          w_req       = 1'b1;
          w_state_nxt = i_px_rd_grant ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        w_req = 1'b1;
        if (i_px_rd_grant) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_px_rd_vld) begin
          w_wr_en     = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = w_last_px ? S_OUT : S_FETCH;
        end
      end
      S_OUT: begin
        w_strip_vld = 1'b1;
        if (i_strip_rdy) begin
          w_strip_acc = 1'b1;
          w_state_nxt = w_last_strip ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (i_op_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_wr_en     = 1'b0;
      w_advance   = 1'b0;
      w_strip_acc = 1'b0;
    end
  end

  // Configuration capture, pixel/strip counters and strip slot writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_width   <= '0;
      r_height  <= '0;
      r_stride2 <= 1'b0;
      r_base    <= '0;
      r_x0      <= '0;
      r_y0      <= '0;
      r_row     <= '0;
      r_lane    <= '0;
      r_strip   <= '0;
    end else begin
      if (w_capture) begin
        r_width   <= i_cfg_width;
        r_height  <= i_cfg_height;
        r_stride2 <= i_cfg_stride2;
        r_base    <= i_base_addr;
        r_x0      <= '0;
        r_y0      <= '0;
        r_row     <= '0;
        r_lane    <= '0;
      end
      if (w_advance) begin
        if (r_lane == LW'(LANES - 1)) begin
          r_lane <= '0;
          r_row  <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_lane <= r_lane + 1'b1;
        end
      end
      if (w_strip_acc) begin
        if (w_x_wrap) begin
          r_x0 <= '0;
          r_y0 <= w_y0_step;
        end else begin
          r_x0 <= w_x0_step;
        end
      end
      for (int s = 0; s < SLOTS; s++) begin
        if (w_wr_en && (w_slot == SW'(s))) begin
          r_strip[s*PX_W +: PX_W] <= w_wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccm_strip_fetch.sv
// Testbench for ccm_strip_fetch: randomized memory and consumer timing,
// checked against a strip/read-list model built directly from the map walk.

module tb_ccm_strip_fetch;

  localparam int ADDR_W = 20;
  localparam int PX_W   = 16;
  localparam int LANES  = 16;
  localparam int ROWS   = 2;
  localparam int DIM_W  = 9;
  localparam int SD_W   = ROWS * LANES * PX_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              op_start = 1'b0;
  logic              op_abort = 1'b0;
  logic [DIM_W-1:0]  cfg_w = '0;
  logic [DIM_W-1:0]  cfg_h = '0;
  logic              cfg_s2 = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic              gnt = 1'b0;
  logic              vld = 1'b0;
  logic [PX_W-1:0]   rdata = '0;
  logic              rdy = 1'b0;
  logic              busy, done, req, svld;
  logic [ADDR_W-1:0] addr;
  logic [SD_W-1:0]   sdata;

  int n_checks = 0;
  int n_fail   = 0;

  // memory / consumer behaviour knobs
  int gnt_max = 0, vld_min = 1, vld_max = 1, rdy_stall = 0;

  // monitor state
  int vld_cnt = 0, gnt_wait = 0, stall_cnt = 0, cyc = 0;
  int n_done = 0, n_busy_after_done = 0, n_multi = 0, n_addr_unstable = 0, n_strip_unstable = 0;
  int first_req_cyc = 0, done_cyc = 0;
  bit seen_req = 0, prev_done = 0, prev_req_hold = 0, prev_stall = 0;
  logic [ADDR_W-1:0] prev_addr = '0, lat_addr = '0;
  logic [SD_W-1:0]   prev_data = '0;

  logic [ADDR_W-1:0] q_rd[$];
  logic [SD_W-1:0]   q_strip[$];
  logic [ADDR_W-1:0] e_rd[$];
  logic [SD_W-1:0]   e_strip[$];

  ccm_strip_fetch #(
    .ADDR_W(ADDR_W), .PX_W(PX_W), .LANES(LANES), .ROWS(ROWS), .DIM_W(DIM_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_op_start(op_start), .i_op_abort(op_abort),
    .o_busy(busy), .o_done(done),
    .i_cfg_width(cfg_w), .i_cfg_height(cfg_h), .i_cfg_stride2(cfg_s2), .i_base_addr(base),
    .o_px_rd_req(req), .o_px_rd_addr(addr), .i_px_rd_grant(gnt), .i_px_rd_vld(vld),
    .i_px_rd_data(rdata),
    .o_strip_data(sdata), .o_strip_vld(svld), .i_strip_rdy(rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [PX_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'h9E3779B1;
    return t[31:16];
  endfunction

  // Pixel memory, strip consumer and protocol monitor, all on the falling edge.
  always @(negedge clk) begin
    if (done) n_done++;
    if (done && done_cyc == 0) done_cyc = cyc;
    if (prev_done && busy) n_busy_after_done++;
    prev_done = done;
    if (req && vld_cnt > 0) n_multi++;
    if (prev_req_hold && req && addr !== prev_addr) n_addr_unstable++;
    if (prev_stall && svld && sdata !== prev_data) n_strip_unstable++;
    if (req && !seen_req) begin seen_req = 1; first_req_cyc = cyc; end

    gnt = 1'b0;
    vld = 1'b0;
    rdata = PX_W'($urandom);
    if (vld_cnt > 0) begin
      vld_cnt--;
      if (vld_cnt == 0) begin vld = 1'b1; rdata = mem_val(lat_addr); end
    end else if (req) begin
      if (gnt_wait == 0) begin
        gnt = 1'b1;
        lat_addr = addr;
        q_rd.push_back(addr);
        vld_cnt = $urandom_range(vld_max, vld_min);
        gnt_wait = $urandom_range(gnt_max, 0);
      end else begin
        gnt_wait--;
      end
    end

    if (svld) begin
      if (stall_cnt < rdy_stall) begin rdy = 1'b0; stall_cnt++; end
      else rdy = 1'b1;
    end else begin
      rdy = 1'($urandom_range(1, 0));
    end
    if (svld && rdy) begin q_strip.push_back(sdata); stall_cnt = 0; end

    prev_req_hold = req && !gnt;
    prev_addr = addr;
    prev_stall = svld && !rdy;
    prev_data = sdata;
    cyc++;
  end

  task automatic do_start(input int w, input int h, input bit s2, input int b);
    @(negedge clk); #1;
    q_rd.delete(); q_strip.delete();
    n_done = 0; n_busy_after_done = 0; n_multi = 0; n_addr_unstable = 0; n_strip_unstable = 0;
    seen_req = 0; first_req_cyc = 0; done_cyc = 0; cyc = 1; stall_cnt = 0;
    cfg_w = DIM_W'(w); cfg_h = DIM_W'(h); cfg_s2 = s2; base = ADDR_W'(b);
    op_start = 1'b1;
    @(negedge clk); #1;
    op_start = 1'b0;
  endtask

  task automatic wait_idle(output bit tmo);
    tmo = 1;
    for (int i = 0; i < 20000; i++) begin
      if (!busy) begin tmo = 0; break; end
      @(negedge clk); #1;
    end
  endtask

  // Reference: walk the map strip by strip and list reads and packed strips.
  task automatic build_model(input int w, input int h, input bit s2, input int b);
    int st;
    st = s2 ? 2 : 1;
    e_rd.delete(); e_strip.delete();
    for (int y0 = 0; y0 < h; y0 += ROWS * st) begin
      for (int x0 = 0; x0 < w; x0 += LANES * st) begin
        logic [SD_W-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
          for (int l = 0; l < LANES; l++) begin
            int x, y, ai;
            logic [ADDR_W-1:0] a;
            y = y0 + r * st;
            x = x0 + l * st;
            if (x < w && y < h) begin
              ai = b + y * w + x;
              a = ADDR_W'(ai);
              e_rd.push_back(a);
              v[(r*LANES+l)*PX_W +: PX_W] = mem_val(a);
            end
          end
        end
        e_strip.push_back(v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req); end
    n_checks++; if (addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr); end
    n_checks++; if (svld !== 1'b0) begin n_fail++; $display("FAIL reset_strip_vld: got %b want 0", svld); end
    n_checks++; if (sdata !== '0) begin n_fail++; $display("FAIL reset_strip_data: nonzero, want 0"); end
  endtask

  task automatic test_full_strips();
    bit tmo; int nm;
    gnt_max = 0; vld_min = 1; vld_max = 1; rdy_stall = 0;
    do_start(32, 4, 0, 0);
    wait_idle(tmo);
    build_model(32, 4, 0, 0);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL full_timeout: busy still %b want 0", busy); end
    n_checks++; if (first_req_cyc !== 1) begin n_fail++; $display("FAIL full_first_req_latency: got %0d want 1", first_req_cyc); end
    nm = 0;
    for (int i = 0; i < e_strip.size() && i < q_strip.size(); i++) if (q_strip[i] !== e_strip[i]) nm++;
    n_checks++; if (q_strip.size() != 4 || nm != 0) begin n_fail++; $display("FAIL full_strips: got %0d strips (%0d differ) want 4", q_strip.size(), nm); end
    nm = 0;
    for (int i = 0; i < e_rd.size() && i < q_rd.size(); i++) if (q_rd[i] !== e_rd[i]) nm++;
    n_checks++; if (q_rd.size() != 128 || nm != 0) begin n_fail++; $display("FAIL full_reads: got %0d reads (%0d wrong addr) want 128", q_rd.size(), nm); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d want 1", n_done); end
    n_checks++; if (n_busy_after_done !== 0) begin n_fail++; $display("FAIL full_busy_after_done: got %0d want 0", n_busy_after_done); end
  endtask

  task automatic test_right_pad();
    bit tmo; int nm; logic [SD_W-1:0] s1; logic [PX_W-1:0] px;
    do_start(20, 2, 0, 'h100);
    wait_idle(tmo);
    build_model(20, 2, 0, 'h100);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL pad_timeout: busy still %b want 0", busy); end
    nm = 0;
    for (int i = 0; i < e_strip.size() && i < q_strip.size(); i++) if (q_strip[i] !== e_strip[i]) nm++;
    n_checks++; if (q_strip.size() != 2 || nm != 0) begin n_fail++; $display("FAIL pad_strips: got %0d strips (%0d differ) want 2", q_strip.size(), nm); end
    nm = 0;
    for (int i = 0; i < e_rd.size() && i < q_rd.size(); i++) if (q_rd[i] !== e_rd[i]) nm++;
    n_checks++; if (q_rd.size() != 40 || nm != 0) begin n_fail++; $display("FAIL pad_reads: got %0d reads (%0d wrong addr) want 40", q_rd.size(), nm); end
    if (q_strip.size() == 2) begin
      s1 = q_strip[1]; nm = 0;
      for (int r = 0; r < ROWS; r++)
        for (int l = 4; l < LANES; l++) begin px = s1[(r*LANES+l)*PX_W +: PX_W]; if (px !== '0) nm++; end
      n_checks++; if (nm != 0) begin n_fail++; $display("FAIL pad_zero_lanes: got %0d nonzero padded lanes want 0", nm); end
    end
  endtask

  task automatic test_stride2();
    bit tmo; int nm;
    do_start(32, 4, 1, 0);
    wait_idle(tmo);
    build_model(32, 4, 1, 0);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL stride2_timeout: busy still %b want 0", busy); end
    nm = 0;
    for (int i = 0; i < e_rd.size() && i < q_rd.size(); i++) if (q_rd[i] !== e_rd[i]) nm++;
    n_checks++; if (q_rd.size() != 32 || nm != 0) begin n_fail++; $display("FAIL stride2_reads: got %0d reads (%0d wrong addr) want 32", q_rd.size(), nm); end
    n_checks++;
    if (q_strip.size() != 1 || q_strip[0] !== e_strip[0]) begin n_fail++; $display("FAIL stride2_strip: got %0d strips or data differs, want 1 matching", q_strip.size()); end
  endtask

  task automatic test_handshake();
    bit tmo; int nm, w, h, b; bit s2;
    gnt_max = 5; vld_min = 1; vld_max = 7; rdy_stall = 10;
    for (int it = 0; it < 3; it++) begin
      w = $urandom_range(40, 1); h = $urandom_range(6, 1);
      s2 = 1'($urandom_range(1, 0)); b = $urandom_range(20'hFFFFF, 0);
      do_start(w, h, s2, b);
      wait_idle(tmo);
      build_model(w, h, s2, b);
      n_checks++; if (tmo) begin n_fail++; $display("FAIL hs_timeout: busy still %b want 0", busy); end
      nm = 0;
      for (int i = 0; i < e_strip.size() && i < q_strip.size(); i++) if (q_strip[i] !== e_strip[i]) nm++;
      n_checks++; if (q_strip.size() != e_strip.size() || nm != 0) begin n_fail++; $display("FAIL hs_strips: got %0d strips (%0d differ) want %0d", q_strip.size(), nm, e_strip.size()); end
      nm = 0;
      for (int i = 0; i < e_rd.size() && i < q_rd.size(); i++) if (q_rd[i] !== e_rd[i]) nm++;
      n_checks++; if (q_rd.size() != e_rd.size() || nm != 0) begin n_fail++; $display("FAIL hs_reads: got %0d reads (%0d wrong addr) want %0d", q_rd.size(), nm, e_rd.size()); end
      n_checks++; if (n_addr_unstable !== 0) begin n_fail++; $display("FAIL hs_addr_stable: got %0d changes want 0", n_addr_unstable); end
      n_checks++; if (n_multi !== 0) begin n_fail++; $display("FAIL hs_outstanding: got %0d overlaps want 0", n_multi); end
      n_checks++; if (n_strip_unstable !== 0) begin n_fail++; $display("FAIL hs_strip_stable: got %0d changes want 0", n_strip_unstable); end
      n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL hs_done_pulses: got %0d want 1", n_done); end
    end
    gnt_max = 0; vld_min = 1; vld_max = 1; rdy_stall = 0;
  endtask

  // Cancel during WAIT with the read data two cycles away, by abort or by reset.
  task automatic test_cancel(input bit use_rst);
    bit tmo; int nm;
    gnt_max = 0; vld_min = 3; vld_max = 3;
    do_start(32, 4, 0, 'h77);
    tmo = 1;
    for (int k = 0; k < 200; k++) begin
      if (!req && busy && vld_cnt == 2) begin tmo = 0; break; end
      @(negedge clk); #1;
    end
    n_checks++; if (tmo) begin n_fail++; $display("FAIL cancel_reach_wait: no WAIT seen, busy %b req %b", busy, req); end
    if (use_rst) rst = 1'b1; else op_abort = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0; op_abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b want 0 (rst=%0d)", busy, use_rst); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL cancel_req: got %b want 0 (rst=%0d)", req, use_rst); end
    n_checks++; if (svld !== 1'b0) begin n_fail++; $display("FAIL cancel_strip_vld: got %b want 0 (rst=%0d)", svld, use_rst); end
    if (use_rst) begin
      n_checks++; if (addr !== '0) begin n_fail++; $display("FAIL cancel_rst_addr: got %h want 0", addr); end
      n_checks++; if (sdata !== '0) begin n_fail++; $display("FAIL cancel_rst_strip_data: nonzero, want 0"); end
    end
    repeat (5) @(negedge clk);
    #1;
    n_checks++; if (n_done !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL cancel_after: done pulses %0d busy %b want 0 0", n_done, busy); end
    vld_min = 1; vld_max = 2;
    do_start(32, 2, 0, 'h40);
    wait_idle(tmo);
    build_model(32, 2, 0, 'h40);
    nm = 0;
    for (int i = 0; i < e_strip.size() && i < q_strip.size(); i++) if (q_strip[i] !== e_strip[i]) nm++;
    n_checks++; if (tmo || q_strip.size() != 2 || nm != 0 || n_done != 1) begin n_fail++; $display("FAIL cancel_restart: got %0d strips (%0d differ) %0d done want 2 0 1", q_strip.size(), nm, n_done); end
    vld_min = 1; vld_max = 1;
  endtask

  task automatic test_degenerate();
    bit tmo;
    do_start(0, 4, 0, 5);
    wait_idle(tmo);
    n_checks++; if (tmo || n_done !== 1) begin n_fail++; $display("FAIL zero_w_done: got %0d pulses want 1", n_done); end
    n_checks++; if (done_cyc < 1 || done_cyc > 2) begin n_fail++; $display("FAIL zero_w_done_latency: got %0d want 1..2", done_cyc); end
    n_checks++; if (q_rd.size() != 0 || q_strip.size() != 0) begin n_fail++; $display("FAIL zero_w_activity: got %0d reads %0d strips want 0 0", q_rd.size(), q_strip.size()); end
    do_start(8, 0, 1, 5);
    wait_idle(tmo);
    n_checks++; if (tmo || n_done !== 1 || q_rd.size() != 0) begin n_fail++; $display("FAIL zero_h: got %0d pulses %0d reads want 1 0", n_done, q_rd.size()); end
  endtask

  task automatic test_start_while_busy();
    bit tmo; int nm;
    do_start(32, 4, 0, 0);
    repeat (20) @(negedge clk);
    #1;
    cfg_w = 16; cfg_h = 2; cfg_s2 = 1'b1; base = 123;
    op_start = 1'b1;
    @(negedge clk); #1;
    op_start = 1'b0;
    wait_idle(tmo);
    build_model(32, 4, 0, 0);
    nm = 0;
    for (int i = 0; i < e_strip.size() && i < q_strip.size(); i++) if (q_strip[i] !== e_strip[i]) nm++;
    n_checks++; if (tmo || q_strip.size() != 4 || nm != 0) begin n_fail++; $display("FAIL busy_start_strips: got %0d strips (%0d differ) want 4", q_strip.size(), nm); end
    n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL busy_start_done: got %0d want 1", n_done); end
  endtask

  initial begin
    test_reset();
    test_full_strips();
    test_right_pad();
    test_stride2();
    test_handshake();
    test_cancel(1'b0);
    test_cancel(1'b1);
    test_degenerate();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
